// File: rtl/arb_pkg.sv
// Shared defaults and payload type for the round-robin bus requester.
// Optional starvation watchdog is enabled in arb_requester by ARB_REQ_WDOG_EN.
package arb_pkg;

    localparam int N_DEF          = 3;
    localparam int DW_DEF         = 8;
    localparam int DEPTH_DEF      = 4;
    localparam int WDOG_LIMIT_DEF = 2 * N_DEF;

    typedef logic [DW_DEF-1:0] payload_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Pending-entry FIFO for arb_requester: storage, wrapping pointers and occupancy count.
// Callers must qualify push with !full and pop with !empty.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Storage, pointer and count update; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head and count come straight from registers so the pop path adds no latency.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
    end

endmodule

// File: rtl/arb_requester.sv
// Requester front-end for a registered round-robin arbiter: buffers local entries,
// requests the bus and pops one entry per grant. Watchdog enabled by ARB_REQ_WDOG_EN.
module arb_requester
    import arb_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DW         = DW_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int WDOG_LIMIT = 2 * N
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          req,
    input  logic          grant,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          err_spurious,
    output logic          starve
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_s;
    logic [DW-1:0] head_s;
    logic          push_s;
    logic          pop_s;
    logic          req_s;
    logic          req_prev_r;
    logic          err_spurious_r;

    arb_req_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data),
        .head      (head_s),
        .count     (count_s)
    );

    // Request drops in the cycle the last entry is popped so the arbiter never over-grants.
    always_comb begin
        push_ready = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        req_s      = 1'b0;
        push_ready = (count_s < DEPTH_C);
        push_s     = push_valid && push_ready;
        pop_s      = grant && (count_s != CW'(0));
        req_s      = ((count_s - CW'(pop_s)) != CW'(0));
        req        = req_s;
        out_valid  = pop_s;
        out_data   = head_s;
    end

    // Grant answers last cycle's request; a grant without one (or with nothing queued) is sticky-flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_prev_r     <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            req_prev_r <= req_s;
            if (grant && ((count_s == CW'(0)) || !req_prev_r)) begin
                err_spurious_r <= 1'b1;
            end
        end
    end

    assign err_spurious = err_spurious_r;

`ifdef ARB_REQ_WDOG_EN
    localparam int            WW      = $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT_C = WW'(WDOG_LIMIT);

    logic [WW-1:0] wait_cnt_r;
    logic [WW-1:0] wait_nxt_s;
    logic          starve_r;

    // Consecutive unanswered-request cycles, saturating at the limit.
    always_comb begin
        wait_nxt_s = WW'(0);
        if (req_s && !grant) begin
            wait_nxt_s = (wait_cnt_r == LIMIT_C) ? LIMIT_C : (wait_cnt_r + WW'(1));
        end else begin
            wait_nxt_s = WW'(0);
        end
    end

    // Wait counter register and sticky starvation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= WW'(0);
            starve_r   <= 1'b0;
        end else begin
            wait_cnt_r <= wait_nxt_s;
            if (wait_nxt_s == LIMIT_C) begin
                starve_r <= 1'b1;
            end
        end
    end

    assign starve = starve_r;
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed vector table, corner sequences,
// randomized traffic against a queue-based model, and a 3-requester round-robin ring.
module tb_arb_requester;
    import arb_pkg::*;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIM   = 2 * N;
`ifdef ARB_REQ_WDOG_EN
    localparam logic STARVE_EXP = 1'b1;
`else
    localparam logic STARVE_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = 8'h00;
    logic          push_ready;
    logic          req;
    logic          grant = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          err_spurious;
    logic          starve;

    always #5 clk = ~clk;

    arb_requester #(.N(N), .DW(DW), .DEPTH(DEPTH), .WDOG_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .req(req), .grant(grant), .out_valid(out_valid),
        .out_data(out_data), .err_spurious(err_spurious), .starve(starve)
    );

    // Three-requester ring with a registered round-robin arbiter
    logic          rr_pv [3];
    logic [DW-1:0] rr_pd [3];
    logic [DW-1:0] rr_od [3];
    logic [2:0]    rr_pr, rr_req, rr_ov, rr_err, rr_starve;
    logic [2:0]    rr_grant;
    logic          rr_arb_en = 1'b0;
    int            rr_last;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rr
        arb_requester #(.N(N), .DW(DW), .DEPTH(DEPTH), .WDOG_LIMIT(LIM)) u_req (
            .clk(clk), .reset(reset), .push_valid(rr_pv[gi]), .push_data(rr_pd[gi]),
            .push_ready(rr_pr[gi]), .req(rr_req[gi]), .grant(rr_grant[gi]),
            .out_valid(rr_ov[gi]), .out_data(rr_od[gi]), .err_spurious(rr_err[gi]),
            .starve(rr_starve[gi])
        );
    end

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_grant <= 3'b000;
            rr_last  <= 2;
        end else if (rr_arb_en && rr_pick(rr_req, rr_last) >= 0) begin
            rr_grant <= 3'b001 << rr_pick(rr_req, rr_last);
            rr_last  <= rr_pick(rr_req, rr_last);
        end else begin
            rr_grant <= 3'b000;
        end
    end

    // Reference model: queue of pending payloads plus sticky flags
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] q[$];
    logic          m_prev_req = 1'b0;
    logic          m_err = 1'b0;
    logic          m_starve = 1'b0;
    int            m_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev_req = 1'b0;
        m_err      = 1'b0;
        m_starve   = 1'b0;
        m_wait     = 0;
    endtask

    task automatic model_edge(input logic pv, input logic [DW-1:0] pd, input logic g);
        int   cnt;
        logic pop, rq;
        cnt = q.size();
        pop = g && (cnt != 0);
        rq  = (cnt - (pop ? 1 : 0)) != 0;
        if (g && (cnt == 0 || !m_prev_req)) m_err = 1'b1;
        if (pop) void'(q.pop_front());
        if (pv && cnt < DEPTH) q.push_back(pd);
        m_prev_req = rq;
        if (rq && !g) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        else m_wait = 0;
`ifdef ARB_REQ_WDOG_EN
        if (m_wait >= LIM) m_starve = 1'b1;
`endif
    endtask

    task automatic check_model(input string tag, input logic g);
        int   cnt;
        logic pop;
        cnt = q.size();
        pop = g && (cnt != 0);
        chk({tag, ".req"}, req, ((cnt - (pop ? 1 : 0)) != 0));
        chk({tag, ".out_valid"}, out_valid, pop);
        if (pop) chk({tag, ".out_data"}, out_data, q[0]);
        chk({tag, ".push_ready"}, push_ready, (cnt < DEPTH));
        chk({tag, ".err"}, err_spurious, m_err);
        chk({tag, ".starve"}, starve, m_starve);
    endtask

    // One cycle: drive at negedge, check before the edge, advance the model after it
    task automatic cyc(input logic pv, input logic [DW-1:0] pd, input logic g, input string tag);
        push_valid = pv;
        push_data  = pd;
        grant      = g;
        #1;
        check_model(tag, g);
        @(posedge clk);
        model_edge(pv, pd, g);
        @(negedge clk);
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        grant      = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.req", req, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.err", err_spurious, 1'b0);
        chk("rst.starve", starve, 1'b0);
        chk("rst.push_ready", push_ready, 1'b1);
        model_reset();
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          g;
        logic          ereq;
        logic          eov;
        logic [DW-1:0] edata;
        logic          epr;
        logic          eerr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vec_t     v;
        logic     pv, g;
        int       seen;
        int       exp_idx[6];
        logic [DW-1:0] exp_dat[6];

        // Single push/grant, then fill to full, overflow attempt, drain in order
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 3; i++) begin
            rr_pv[i] = 1'b0;
            rr_pd[i] = 8'h00;
        end

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            push_valid = v.pv;
            push_data  = v.pd;
            grant      = v.g;
            #1;
            chk($sformatf("vec%0d.req", i), req, v.ereq);
            chk($sformatf("vec%0d.out_valid", i), out_valid, v.eov);
            if (v.eov) chk($sformatf("vec%0d.out_data", i), out_data, v.edata);
            chk($sformatf("vec%0d.push_ready", i), push_ready, v.epr);
            chk($sformatf("vec%0d.err", i), err_spurious, v.eerr);
            chk($sformatf("vec%0d.starve", i), starve, 1'b0);
            @(posedge clk);
            model_edge(v.pv, v.pd, v.g);
            @(negedge clk);
        end

        // Push and pop together at count 2: count holds, order preserved
        do_reset();
        cyc(1'b1, 8'h11, 1'b0, "pp.push1");
        cyc(1'b1, 8'h22, 1'b0, "pp.push2");
        cyc(1'b1, 8'h33, 1'b1, "pp.both");
        chk("pp.count_held", q.size(), 2);
        cyc(1'b0, 8'h00, 1'b1, "pp.pop2");
        cyc(1'b0, 8'h00, 1'b1, "pp.pop3");
        cyc(1'b0, 8'h00, 1'b0, "pp.idle");
        chk("pp.no_err", err_spurious, 1'b0);

        // Watchdog: request held unanswered for WDOG_LIMIT cycles
        do_reset();
        cyc(1'b1, 8'h77, 1'b0, "wd.push");
        for (int i = 0; i < LIM; i++) cyc(1'b0, 8'h00, 1'b0, "wd.wait");
        chk("wd.starve", starve, STARVE_EXP);
        cyc(1'b0, 8'h00, 1'b1, "wd.drain");
        cyc(1'b0, 8'h00, 1'b0, "wd.sticky");

        // Grant on empty FIFO: no transfer, sticky error
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, "spur.grant");
        chk("spur.set", err_spurious, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, "spur.hold1");
        cyc(1'b1, 8'h44, 1'b0, "spur.hold2");
        chk("spur.held", err_spurious, 1'b1);

        // Grant with data queued but no request in the previous cycle
        do_reset();
        cyc(1'b1, 8'h3C, 1'b0, "early.push");
        cyc(1'b0, 8'h00, 1'b1, "early.grant");
        chk("early.err", err_spurious, 1'b1);

        // Asynchronous reset mid-operation discards entries
        do_reset();
        cyc(1'b1, 8'h51, 1'b0, "mid.p1");
        cyc(1'b1, 8'h52, 1'b0, "mid.p2");
        cyc(1'b1, 8'h53, 1'b0, "mid.p3");
        push_valid = 1'b1;
        push_data  = 8'h54;
        #2 reset = 1'b1;
        #1;
        chk("mid.req", req, 1'b0);
        chk("mid.push_ready", push_ready, 1'b1);
        chk("mid.out_valid", out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        push_valid = 1'b0;
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, "mid.release");
        cyc(1'b0, 8'h00, 1'b0, "mid.after");

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) begin
                do_reset();
            end else begin
                pv = ($urandom_range(0, 1) == 1);
                g  = m_prev_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
                cyc(pv, 8'($urandom_range(0, 255)), g, "rand");
            end
        end

        // Three requesters, two entries each, sharing the round-robin arbiter
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                rr_pv[i] = 1'b1;
                rr_pd[i] = 8'((i * 16) + k + 1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) rr_pv[i] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            exp_idx[j] = j % 3;
            exp_dat[j] = 8'(((j % 3) * 16) + (j / 3) + 1);
        end
        rr_arb_en = 1'b1;
        seen = 0;
        for (int c = 0; c < 30 && seen < 6; c++) begin
            #1;
            if (rr_grant != 3'b000) begin
                chk("ring.grant", rr_grant, 3'b001 << exp_idx[seen]);
                chk("ring.out_valid", rr_ov, 3'b001 << exp_idx[seen]);
                chk("ring.out_data", rr_od[exp_idx[seen]], exp_dat[seen]);
                seen++;
            end
            @(negedge clk);
        end
        chk("ring.transfers", seen, 6);
        @(negedge clk);
        #1;
        chk("ring.req_idle", rr_req, 3'b000);
        chk("ring.grant_idle", rr_grant, 3'b000);
        chk("ring.err", rr_err, 3'b000);
        chk("ring.push_ready", rr_pr, 3'b111);
        rr_arb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the number of requesters on the round-robin bus.
REQ-002 The block SHALL have parameter DW, default 8, meaning the payload width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the pending-entry FIFO depth (power of 2, >= 2).
REQ-004 The block SHALL have parameter WDOG_LIMIT, default 2*N, meaning the starvation threshold in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port push_valid, input, 1 bit: local source offers an entry.
REQ-008 The block SHALL have port push_data, input, DW bits: payload of the offered entry.
REQ-009 The block SHALL have port push_ready, output, 1 bit: FIFO can accept an entry.
REQ-010 The block SHALL have port req, output, 1 bit: request line to the arbiter.
REQ-011 The block SHALL have port grant, input, 1 bit: this requester's registered one-hot grant bit from the arbiter.
REQ-012 The block SHALL have port out_valid, output, 1 bit: a transfer occurs this cycle.
REQ-013 The block SHALL have port out_data, output, DW bits: payload of the current transfer.
REQ-014 The block SHALL have port err_spurious, output, 1 bit: sticky flag for a grant received without a request.
REQ-015 The block SHALL have port starve, output, 1 bit: sticky starvation flag.

Function
REQ-016 A push SHALL occur when push_valid && push_ready; push_ready = (count < DEPTH).
REQ-017 Grant timing: grant in cycle t answers req in cycle t-1; each grant cycle SHALL pop exactly one FIFO head entry.
REQ-018 req SHALL equal ((count - (grant && count!=0)) != 0), combinationally, so no request is left outstanding for an entry already being popped.
REQ-019 out_valid SHALL equal grant && (count != 0), and out_data SHALL be the FIFO head in the same cycle, with zero added latency.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 A push into an empty FIFO raises req the following cycle, so the earliest out_valid is 2 cycles after the push.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL span 0..DEPTH and use $clog2(DEPTH)+1 bits.
REQ-023 grant while count==0 SHALL cause no pop, keep out_valid at 0, and set err_spurious on the next edge; err_spurious SHALL stay set until reset.
REQ-024 grant while count!=0 but req was 0 in the previous cycle SHALL still pop, and SHALL also set err_spurious.

Reset
REQ-025 While reset is high: count=0, pointers=0, req=0, out_valid=0, err_spurious=0, starve=0, watchdog counter=0, and push_ready=1 after reset releases.
REQ-026 Reset asserted mid-operation SHALL discard all pending entries immediately, with no out_valid on the reset-release cycle.

Configuration
REQ-027 With macro ARB_REQ_WDOG_EN defined, a wait counter SHALL increment each cycle req && !grant and clear otherwise.
REQ-028 With ARB_REQ_WDOG_EN defined, starve SHALL set, and stay set, when the wait counter reaches WDOG_LIMIT.
REQ-029 With ARB_REQ_WDOG_EN undefined, the wait counter SHALL be absent and starve SHALL be tied to 0.

Structure
REQ-030 Package arb_pkg SHALL hold the default N, DW, DEPTH and WDOG_LIMIT constants, and a typedef for the payload word.
REQ-031 Storage and pointers SHALL live in sub-module arb_req_fifo (push/pop/head/count); req, error and watchdog logic SHALL live in arb_requester.

Verification
REQ-032 Push 0xA5 into an empty FIFO at cycle 0 -> req=1 at cycle 1; arbiter grant at cycle 2 -> out_valid=1, out_data=0xA5, req=0 at cycle 2.
REQ-033 Push 4 entries 0x01..0x04 with no grant -> push_ready=0; a 5th push is ignored; grants on 4 cycles -> outputs 0x01..0x04 in order, then req=0.
REQ-034 Hold count=2 and push and grant in the same cycle -> count stays 2 and the output order is preserved.
REQ-035 Drive grant=1 with an empty FIFO -> out_valid=0, err_spurious=1 from the next cycle, held until reset.
REQ-036 With ARB_REQ_WDOG_EN, N=3, hold req with grant=0 for 6 cycles -> starve=1; without the macro -> starve=0.
REQ-037 Connect 3 instances to the arbiter, all with 2 entries -> grants rotate 0,1,2,0,1,2, with no spurious grant and all FIFOs empty after 6 transfers.
